// File: rtl/mul_unit_if.sv
// mul_unit_if: handshake and operand/result bundle for the iterative multiplier.
//   slave  modport (the multiplier): start, accumulate, set_flags, Rm, Rs, Rn,
//          ARd_in in; busy, done, result, ARd_out, wen_Rd, flag_n, flag_z out.
//   master modport (control path / register file): the mirror image.
interface mul_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             accumulate;
   logic             set_flags;
   logic [WIDTH-1:0] Rm;
   logic [WIDTH-1:0] Rs;
   logic [WIDTH-1:0] Rn;
   logic [3:0]       ARd_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic [3:0]       ARd_out;
   logic             wen_Rd;
   logic             flag_n;
   logic             flag_z;

   modport slave (
      input  start, accumulate, set_flags, Rm, Rs, Rn, ARd_in,
      output busy, done, result, ARd_out, wen_Rd, flag_n, flag_z
   );

   modport master (
      output start, accumulate, set_flags, Rm, Rs, Rn, ARd_in,
      input  busy, done, result, ARd_out, wen_Rd, flag_n, flag_z
   );
endinterface

// File: rtl/mul_unit.sv
// mul_unit: iterative shift-add multiplier for ARM MUL / MLA.
//   Rd = Rm*Rs (MUL) or Rd = Rm*Rs + Rn (MLA), low WIDTH bits only.
//   Ports:
//     clk  - clock, rising edge
//     rst  - synchronous active-high reset, aborts any operation
//     bus  - mul_unit_if.slave: start/operands in, busy/done/result/
//            ARd_out/wen_Rd/flag_n/flag_z out
//   Each operation takes WIDTH/STEP RUN cycles followed by a single DONE
//   cycle; a new start may be accepted in that DONE cycle.
module mul_unit #(
   parameter int WIDTH = 32,
   parameter int STEP  = 1
) (
   input logic       clk,
   input logic       rst,
   mul_unit_if.slave bus
);

   localparam int N  = WIDTH / STEP;
   localparam int CW = $clog2(N + 1);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   generate
      if (!(STEP == 1 || STEP == 2 || STEP == 4)) begin : g_bad_step
         $error("mul_unit: STEP must be 1, 2 or 4");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic             sf_lat;
   logic [3:0]       ard_lat;

   logic             busy_r;
   logic             done_r;
   logic [WIDTH-1:0] result_r;
   logic [3:0]       ard_out_r;
   logic             wen_r;
   logic             flag_n_r;
   logic             flag_z_r;

   logic [WIDTH-1:0] partial;
   logic [WIDTH-1:0] acc_next;

   // Partial product for this cycle: the multiplicand (already pre-shifted
   // by the bits retired so far) times the low STEP bits of the multiplier.
   // Built as a small sum of shifted copies so no real multiplier is needed.
   always_comb begin
      partial = '0;
      for (int i = 0; i < STEP; i++) begin
         if (mplier[i]) begin
            partial = partial + (mcand << i);
         end
      end
      acc_next = acc + partial;
   end

   // Single control process. Outputs are registered; result, ARd_out and
   // the flags are only written on entry to DONE so they hold across IDLE.
   // done and wen_Rd default low every cycle so they pulse for one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         count     <= '0;
         acc       <= '0;
         mcand     <= '0;
         mplier    <= '0;
         sf_lat    <= 1'b0;
         ard_lat   <= 4'd0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         result_r  <= '0;
         ard_out_r <= 4'd0;
         wen_r     <= 1'b0;
         flag_n_r  <= 1'b0;
         flag_z_r  <= 1'b0;
      end else begin
         done_r <= 1'b0;
         wen_r  <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  mcand   <= bus.Rm;
                  mplier  <= bus.Rs;
                  acc     <= bus.accumulate ? bus.Rn : '0;
                  sf_lat  <= bus.set_flags;
                  ard_lat <= bus.ARd_in;
                  count   <= '0;
                  busy_r  <= 1'b1;
                  state   <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               acc    <= acc_next;
               mcand  <= mcand << STEP;
               mplier <= mplier >> STEP;
               count  <= count + 1'b1;
               // Fixed latency: the last retirement step finishes the op.
               if (count == LAST) begin
                  state     <= DONE;
                  busy_r    <= 1'b0;
                  done_r    <= 1'b1;
                  result_r  <= acc_next;
                  ard_out_r <= ard_lat;
                  // R15 is the PC and is never written from here.
                  wen_r     <= (ard_lat != 4'd15);
                  if (sf_lat) begin
                     flag_n_r <= acc_next[WIDTH-1];
                     flag_z_r <= (acc_next == '0);
                  end
               end
            end
            default: begin
               state  <= IDLE;
               busy_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy    = busy_r;
   assign bus.done    = done_r;
   assign bus.result  = result_r;
   assign bus.ARd_out = ard_out_r;
   assign bus.wen_Rd  = wen_r;
   assign bus.flag_n  = flag_n_r;
   assign bus.flag_z  = flag_z_r;

endmodule

// File: tb/tb_mul_unit.sv
// tb_mul_unit: directed self-checking bench for mul_unit.
//   Two instances: STEP=1 (main sequence) and STEP=4 (latency check).
//   Expected results are computed by a behavioural model when an operation
//   is started, queued, and compared when done is observed.
module tb_mul_unit;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   mul_unit_if #(.WIDTH(32)) b1 ();
   mul_unit_if #(.WIDTH(32)) b4 ();

   mul_unit #(.WIDTH(32), .STEP(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
   mul_unit #(.WIDTH(32), .STEP(4)) dut4 (.clk(clk), .rst(rst), .bus(b4.slave));

   typedef struct {
      logic [31:0] res;
      logic [3:0]  ard;
      logic        wen;
      logic        n;
      logic        z;
   } exp_t;

   exp_t sbq[$];
   int checks = 0;
   int errors = 0;
   logic model_n = 1'b0;
   logic model_z = 1'b0;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: full-width product truncated to 32 bits.
   task automatic pushExpected(input logic [31:0] rm, input logic [31:0] rs, input logic [31:0] rn,
                               input logic acc, input logic sf, input logic [3:0] ard);
      exp_t e;
      logic [63:0] full;
      full = 64'(rm) * 64'(rs) + (acc ? 64'(rn) : 64'd0);
      e.res = full[31:0];
      e.ard = ard;
      e.wen = (ard != 4'd15);
      if (sf) begin
         model_n = e.res[31];
         model_z = (e.res == 32'd0);
      end
      e.n = model_n;
      e.z = model_z;
      sbq.push_back(e);
   endtask

   // Drive a start on b1 for one edge and record the expected outcome.
   task automatic applyStimulus(input logic [31:0] rm, input logic [31:0] rs, input logic [31:0] rn,
                                input logic acc, input logic sf, input logic [3:0] ard);
      b1.Rm = rm; b1.Rs = rs; b1.Rn = rn;
      b1.accumulate = acc; b1.set_flags = sf; b1.ARd_in = ard;
      b1.start = 1'b1;
      pushExpected(rm, rs, rn, acc, sf, ard);
      tick();
      b1.start = 1'b0;
      checkOutput("busy_after_start", 32'(b1.busy), 32'd1);
   endtask

   // Wait for done on b1, checking latency, then compare against the queue.
   task automatic waitDone(input int already, input int expLat);
      int  lat = already;
      bit  got = 1'b0;
      exp_t e;
      while (!got && lat < expLat + 20) begin
         tick();
         lat++;
         if (b1.done === 1'b1) got = 1'b1;
      end
      checkOutput("done_latency", 32'(lat), 32'(expLat));
      if (!got) return;
      if (sbq.size() == 0) begin
         checkOutput("scoreboard_nonempty", 32'd0, 32'd1);
         return;
      end
      e = sbq.pop_front();
      checkOutput("result", b1.result, e.res);
      checkOutput("ARd_out", 32'(b1.ARd_out), 32'(e.ard));
      checkOutput("wen_Rd", 32'(b1.wen_Rd), 32'(e.wen));
      checkOutput("flag_n", 32'(b1.flag_n), 32'(e.n));
      checkOutput("flag_z", 32'(b1.flag_z), 32'(e.z));
      checkOutput("busy_in_done", 32'(b1.busy), 32'd0);
   endtask

   initial begin
      b1.start = 1'b0; b1.accumulate = 1'b0; b1.set_flags = 1'b0;
      b1.Rm = '0; b1.Rs = '0; b1.Rn = '0; b1.ARd_in = '0;
      b4.start = 1'b0; b4.accumulate = 1'b0; b4.set_flags = 1'b0;
      b4.Rm = '0; b4.Rs = '0; b4.Rn = '0; b4.ARd_in = '0;

      // Reset state
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      checkOutput("rst_busy", 32'(b1.busy), 32'd0);
      checkOutput("rst_done", 32'(b1.done), 32'd0);
      checkOutput("rst_wen", 32'(b1.wen_Rd), 32'd0);
      checkOutput("rst_result", b1.result, 32'd0);
      checkOutput("rst_ard", 32'(b1.ARd_out), 32'd0);
      checkOutput("rst_flags", 32'({b1.flag_n, b1.flag_z}), 32'd0);

      // 1: MUL 7*6 -> 42, then idle with result held
      applyStimulus(32'd7, 32'd6, 32'd0, 1'b0, 1'b0, 4'd3);
      waitDone(0, 32);
      tick();
      checkOutput("t1_done_low", 32'(b1.done), 32'd0);
      checkOutput("t1_wen_low", 32'(b1.wen_Rd), 32'd0);
      checkOutput("t1_idle_busy", 32'(b1.busy), 32'd0);
      tick();
      checkOutput("t1_result_held", b1.result, 32'd42);

      // 2: MLA wrap and negative result flag
      applyStimulus(32'hFFFF_FFFF, 32'd2, 32'd3, 1'b1, 1'b1, 4'd1);
      waitDone(0, 32);
      tick();
      applyStimulus(32'h8000_0000, 32'd1, 32'd0, 1'b0, 1'b1, 4'd2);
      waitDone(0, 32);
      tick();

      // 3: zero result sets Z; following op without S keeps flags
      applyStimulus(32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0, 1'b1, 4'd4);
      waitDone(0, 32);
      tick();
      applyStimulus(32'd5, 32'd5, 32'd0, 1'b0, 1'b0, 4'd5);
      waitDone(0, 32);
      tick();

      // 4: start during RUN ignored; start in DONE accepted back-to-back
      applyStimulus(32'd11, 32'd13, 32'd0, 1'b0, 1'b0, 4'd6);
      for (int i = 1; i <= 4; i++) tick();
      b1.Rm = 32'd99; b1.Rs = 32'd77; b1.Rn = 32'd5; b1.accumulate = 1'b1; b1.ARd_in = 4'd9;
      b1.start = 1'b1;
      tick();
      b1.start = 1'b0;
      waitDone(5, 32);
      applyStimulus(32'd3, 32'd3, 32'd0, 1'b0, 1'b0, 4'd7);
      waitDone(0, 32);
      tick();

      // 5: reset mid-RUN aborts with no done/wen pulse
      applyStimulus(32'd123, 32'd456, 32'd0, 1'b0, 1'b1, 4'd8);
      for (int i = 1; i <= 9; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      void'(sbq.pop_back());
      model_n = 1'b0;
      model_z = 1'b0;
      checkOutput("abort_busy", 32'(b1.busy), 32'd0);
      checkOutput("abort_result", b1.result, 32'd0);
      checkOutput("abort_flags", 32'({b1.flag_n, b1.flag_z}), 32'd0);
      begin
         bit saw = 1'b0;
         for (int i = 0; i < 40; i++) begin
            if (b1.done === 1'b1 || b1.wen_Rd === 1'b1) saw = 1'b1;
            tick();
         end
         checkOutput("abort_no_pulse", 32'(saw), 32'd0);
      end

      // 6: destination R15 suppresses write enable
      applyStimulus(32'd2, 32'd2, 32'd0, 1'b0, 1'b0, 4'd15);
      waitDone(0, 32);
      tick();

      // STEP=4 instance: 8 RUN cycles
      b4.Rm = 32'd7; b4.Rs = 32'd6; b4.Rn = 32'd0; b4.accumulate = 1'b0;
      b4.set_flags = 1'b0; b4.ARd_in = 4'd3; b4.start = 1'b1;
      tick();
      b4.start = 1'b0;
      checkOutput("s4_busy", 32'(b4.busy), 32'd1);
      begin
         int lat = 0;
         bit got = 1'b0;
         while (!got && lat < 40) begin
            tick();
            lat++;
            if (b4.done === 1'b1) got = 1'b1;
         end
         checkOutput("s4_latency", 32'(lat), 32'd8);
         checkOutput("s4_result", b4.result, 32'd42);
         checkOutput("s4_wen", 32'(b4.wen_Rd), 32'd1);
         checkOutput("s4_ard", 32'(b4.ARd_out), 32'd3);
      end
      tick();
      checkOutput("s4_done_low", 32'(b4.done), 32'd0);

      checkOutput("scoreboard_drained", 32'(sbq.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mul_unit.md
Name: mul_unit

Overview:
Iterative multiply / multiply-accumulate unit implementing ARM MUL and MLA: Rd = Rm*Rs, or Rd = Rm*Rs + Rn. It sits directly downstream of the register file. It consumes the Rm, Rs and Rn read ports and produces the Rd_data value and write enable for register-file writeback. It is a multi-cycle shift-add engine with a start/done handshake, so the control path stalls the pipeline while busy is high.

Parameters:
WIDTH, 32, operand and result width in bits.
STEP, 1, multiplier bits retired per RUN cycle. Legal values are 1, 2 and 4; any other value is an elaboration error. N = WIDTH/STEP RUN cycles per operation.

Ports:
clk  input  1  clock, all state updates on the rising edge.
rst  input  1  reset, synchronous, active-high.
start  input  1  request a new operation; sampled only in IDLE or DONE.
accumulate  input  1  1 = MLA (add Rn), 0 = MUL; latched at start.
set_flags  input  1  S bit; latched at start.
Rm  input  WIDTH  multiplicand; latched at start.
Rs  input  WIDTH  multiplier; latched at start.
Rn  input  WIDTH  accumulate operand; latched at start.
ARd_in  input  4  destination register index; latched at start.
busy  output  1  high in RUN; the decoder holds the next instruction while high.
done  output  1  one-cycle pulse, result valid.
result  output  WIDTH  product (+Rn), to Rd_data; held until the next accepted start.
ARd_out  output  4  latched destination index.
wen_Rd  output  1  register-file write enable for result.
flag_n  output  1  N flag.
flag_z  output  1  Z flag.

Behaviour:
- States: IDLE, RUN, DONE. Reset puts the block in IDLE with busy=0, done=0, wen_Rd=0, result=0, ARd_out=0, flag_n=0, flag_z=0, and the internal counter and accumulator cleared.
- IDLE: on start=1 at edge E0, latch Rm, Rs, Rn, accumulate, set_flags and ARd_in. Initialise accumulator = accumulate ? Rn : 0 and counter = 0, then go to RUN.
- RUN:
  - Each edge adds Rm*(next STEP low bits of the multiplier), shifted left by counter*STEP, to the accumulator. Equivalently: shift the multiplicand left by STEP and the multiplier right by STEP.
  - The counter increments. After the N-th RUN edge (edge EN) the state goes to DONE.
  - No early termination: latency is fixed.
- Arithmetic: only the low WIDTH bits are kept; all additions and shifts wrap modulo 2^WIDTH. Operands are unsigned, which gives a low word identical to the signed result.
- DONE, which lasts exactly one cycle:
  - done=1 and result = accumulator.
  - wen_Rd = 1 if ARd_out != 15, otherwise 0. The PC is never written by this block; done still pulses.
  - If the latched set_flags=1, then flag_n = result[WIDTH-1] and flag_z = (result==0). Otherwise both flags hold their previous values.
- Exit from DONE: with start=0 the next state is IDLE. With start=1 a new operation is accepted exactly as from IDLE (back-to-back).
- Timing: start sampled at edge E0 gives done high between edges E(N) and E(N+1). For N=32 that is one cycle, 32 cycles after the start edge.
- busy is high exactly in RUN. start is ignored while in RUN, and operand inputs changing during RUN have no effect.
- result, ARd_out and the flags hold after DONE until the next DONE; they are not cleared on return to IDLE.
- rst=1 in any state, including mid-RUN, aborts the operation:
  - All outputs return to their reset values on that edge.
  - No done or wen_Rd pulse is produced for the aborted operation.
  - rst takes priority over start.

Test Plan:
1. STEP=1, MUL Rm=7, Rs=6, ARd_in=3, start at E0 -> busy high for 32 cycles; done=1, wen_Rd=1, result=42, ARd_out=3 in the single cycle after E32; idle afterwards with result still 42.
2. MLA Rm=0xFFFFFFFF, Rs=2, Rn=3, set_flags=1 -> result=0x00000001, flag_n=0, flag_z=0. Then MUL 0x80000000*1 with set_flags=1 -> result=0x80000000, flag_n=1, flag_z=0.
3. MUL 0x00010000*0x00010000 with set_flags=1 -> result=0, flag_z=1, flag_n=0. A following MUL 5*5 with set_flags=0 -> result=25, flags remain n=0, z=1.
4. Pulse start again at RUN cycle 5 with new operands -> ignored; original result produced. Assert start during the DONE cycle with Rm=3, Rs=3 -> accepted, second done 32 cycles later with result=9, no IDLE cycle between.
5. Assert rst at RUN cycle 10 -> next cycle busy=0, result=0, flags=0; no done or wen_Rd pulse within the following 40 cycles.
6. ARd_in=15, MUL 2*2 -> done pulses with result=4 and wen_Rd=0. Re-run test 1 with STEP=4 -> done after 8 RUN cycles, result=42.
